mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares the single cached memory bus between the fetch port (IF) and the data port (MEM).
// - Sequences one single-beat transaction at a time.
// - Generates the Iwait/Dwait stall levels consumed by the pipeline registers, including MEM/WB.
// - Sits between the core pipeline and the cbus interface.
// PARAMETERS
// ADDR_W     64  request address width
// DATA_W     64  data width; strobe width is DATA_W/8
// STARVE_MAX 4   consecutive data grants allowed while fetch waits, before fetch is forced once
// PORTS
// clk            in   1         clock; all state changes on posedge
// reset          in   1         synchronous, active-high
// ireq_valid     in   1         fetch request; held stable until iresp_ok
// ireq_addr      in   ADDR_W    fetch address
// dreq_valid     in   1         data request; held stable until dresp_ok
// dreq_is_write  in   1         1=store, 0=load
// dreq_size      in   3         msize_t (byte..dword)
// dreq_addr      in   ADDR_W    data address
// dreq_strobe    in   DATA_W/8  byte enables (writes only)
// dreq_data      in   DATA_W    store data
// creq_valid     out  1         bus request, registered
// creq_is_write  out  1         registered copy of the granted request
// creq_size      out  3         registered; fetch always MSIZE8
// creq_addr      out  ADDR_W    registered
// creq_strobe    out  DATA_W/8  registered; 0 for fetch and loads
// creq_data      out  DATA_W    registered; 0 for fetch
// cresp_ready    in   1         bus response beat valid
// cresp_last     in   1         final beat (always 1 for single-beat)
// cresp_data     in   DATA_W    response data
// iresp_ok       out  1         1-cycle pulse: fetch done, iresp_data valid
// iresp_data     out  DATA_W    equals cresp_data in the iresp_ok cycle
// dresp_ok       out  1         1-cycle pulse: data done
// dresp_data     out  DATA_W    equals cresp_data in the dresp_ok cycle
// Iwait          out  1         ireq_valid & ~iresp_ok
// Dwait          out  1         dreq_valid & ~dresp_ok
// BEHAVIOUR
// - FSM states: IDLE, BUSY_I, BUSY_D.
// - Reset: state=IDLE, starve_cnt=0, all creq_* outputs = 0.
// - iresp_ok and dresp_ok are 0 out of reset.
// - IDLE, grant decision:
//   - Only dreq pending -> BUSY_D.
//   - Only ireq pending -> BUSY_I.
//   - Both pending -> BUSY_D, unless starve_cnt==STARVE_MAX, in which case BUSY_I.
//   - At the grant edge: creq_* loaded from the winner and creq_valid<=1 (latency 1 cycle).
// - BUSY_x: creq_* held constant.
//   - In the cycle with cresp_ready&cresp_last: x_resp_ok=1 (combinational).
//   - At that edge: creq_valid<=0 and state->IDLE. No back-to-back grant from BUSY.
//   - Minimum transaction length: 2 cycles + bus latency.
// - starve_cnt:
//   - Incremented (saturating at STARVE_MAX) on a D grant while ireq_valid=1.
//   - Cleared on any I grant, and on a D grant while ireq_valid=0.
// - Response pulses are only produced in the matching BUSY state.
//   - cresp_ready in IDLE is ignored.
//   - Responses are never cross-routed.
// - A requester dropping valid mid-transaction is a protocol violation.
//   - The bus transaction still completes and the ok pulse is still issued.
// - Simultaneous new request and completion: the new request waits for IDLE.
// - Reset mid-transaction: next edge returns to IDLE with creq_valid=0; no ok pulse is issued.
// STRUCTURE
// - common package gets:
//   - arb_state_t enum {IDLE, BUSY_I, BUSY_D}
//   - msize_t (shared with dreq)
//   - creq_t packed struct {valid, is_write, size, addr, strobe, data}
// - creq_* are driven from one registered creq_t.
// - One sub-module, arb_starve_counter: saturating counter with inc/clr/full.
// - FSM and datapath muxing stay in this module.
// TESTING
// - Reset, then ireq_valid=1 addr=0x8000_0000 -> creq_valid=1 next cycle, creq_size=MSIZE8.
//   - cresp_ready after 3 cycles -> iresp_ok pulse of 1 cycle; Iwait high until that cycle.
// - Both requests in one cycle (dreq load 0x8000_1000) -> D granted first.
//   - I granted in the IDLE cycle after dresp_ok; Iwait stays 1 throughout.
// - ireq held while 5 back-to-back D stores arrive -> after 4 D grants, I is granted.
//   - Then D resumes; starve_cnt reads 0 after the I grant.
// - Store: dreq_strobe=8'h0F, data=0x1122334455667788 -> creq_strobe/data match.
//   - Values held constant until completion; dresp_ok only.
// - cresp_ready pulsed in IDLE -> no iresp_ok/dresp_ok and no state change.
// - reset asserted in BUSY_D before cresp -> creq_valid=0 next cycle, no dresp_ok, state IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared types for the memory bus arbiter: arbiter FSM states, access size
//   encoding (shared with the data request port) and the registered bus
//   request record that drives the creq_* outputs.
package mem_bus_arbiter_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    msize_t                size;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_STRB_W-1:0] strobe;
    logic [ARB_DATA_W-1:0] data;
  } creq_t;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter
//   Saturating count of consecutive data grants taken while fetch was waiting.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     inc        : count one more data grant (holds at MAX)
//     clr        : restart from zero (wins over inc)
//     full       : count has reached MAX, fetch must win the next tie
//     cnt        : current count
//   MAX must be at least 1.
module arb_starve_counter #(
  parameter  int MAX   = 4,
  localparam int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == CNT_W'(MAX));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (inc && !full)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single cached memory bus between the fetch port (ireq) and the
//   data port (dreq), one single-beat transaction at a time, and produces the
//   Iwait/Dwait stall levels for the pipeline registers.
//   Ports:
//     clk, reset       : clock, synchronous active-high reset
//     ireq_*           : fetch request, held until iresp_ok
//     dreq_*           : data request (load/store), held until dresp_ok
//     creq_*           : registered bus request towards cbus
//     cresp_*          : bus response beat
//     iresp_*, dresp_* : completion pulse + data back to each requester
//     Iwait, Dwait     : requester has a request outstanding this cycle
//   ADDR_W/DATA_W must agree with the widths baked into creq_t.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  input  logic                dreq_valid,
  input  logic                dreq_is_write,
  input  logic [2:0]          dreq_size,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                creq_valid,
  output logic                creq_is_write,
  output logic [2:0]          creq_size,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                cresp_ready,
  input  logic                cresp_last,
  input  logic [DATA_W-1:0]   cresp_data,
  output logic                iresp_ok,
  output logic [DATA_W-1:0]   iresp_data,
  output logic                dresp_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                Iwait,
  output logic                Dwait
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t       state_q, state_d;
  creq_t            creq_q, creq_d;
  logic             grant_i, grant_d;
  logic             done;
  logic             starve_full;
  logic [CNT_W-1:0] starve_cnt;

  // A response beat only completes a transaction while one is in flight;
  // a reset in the same cycle swallows the completion.
  assign done = (state_q != IDLE) && cresp_ready && cresp_last && !reset;

  always_comb begin
    state_d = state_q;
    creq_d  = creq_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins ties unless fetch has been passed over STARVE_MAX times.
        if (dreq_valid && !(ireq_valid && starve_full)) grant_d = 1'b1;
        else if (ireq_valid)                            grant_i = 1'b1;

        if (grant_d) begin
          state_d         = BUSY_D;
          creq_d.valid    = 1'b1;
          creq_d.is_write = dreq_is_write;
          creq_d.size     = msize_t'(dreq_size);
          creq_d.addr     = dreq_addr;
          creq_d.strobe   = dreq_is_write ? dreq_strobe : '0;
          creq_d.data     = dreq_data;
        end else if (grant_i) begin
          state_d         = BUSY_I;
          creq_d.valid    = 1'b1;
          creq_d.is_write = 1'b0;
          creq_d.size     = MSIZE8;
          creq_d.addr     = ireq_addr;
          creq_d.strobe   = '0;
          creq_d.data     = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // Always drop back to IDLE so the next grant is decided afresh.
        if (done) begin
          state_d = IDLE;
          creq_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      creq_q  <= '0;
    end else begin
      state_q <= state_d;
      creq_q  <= creq_d;
    end
  end

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d && ireq_valid),
    .clr   (grant_i || (grant_d && !ireq_valid)),
    .full  (starve_full),
    .cnt   (starve_cnt)
  );

  assign creq_valid    = creq_q.valid;
  assign creq_is_write = creq_q.is_write;
  assign creq_size     = creq_q.size;
  assign creq_addr     = creq_q.addr;
  assign creq_strobe   = creq_q.strobe;
  assign creq_data     = creq_q.data;

  assign iresp_ok   = done && (state_q == BUSY_I);
  assign dresp_ok   = done && (state_q == BUSY_D);
  assign iresp_data = cresp_data;
  assign dresp_data = cresp_data;

  assign Iwait = ireq_valid && !iresp_ok;
  assign Dwait = dreq_valid && !dresp_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        dreq_valid, dreq_is_write;
  logic [2:0]  dreq_size;
  logic [63:0] dreq_addr;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready, cresp_last;
  logic [63:0] cresp_data;
  logic        iresp_ok, dresp_ok, Iwait, Dwait;
  logic [63:0] iresp_data, dresp_data;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .dreq_valid(dreq_valid), .dreq_is_write(dreq_is_write), .dreq_size(dreq_size),
    .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .Iwait(Iwait), .Dwait(Dwait)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the bus, what it asked for, and how
  // many data grants in a row have jumped over a waiting fetch.
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  int          m_streak = 0;
  logic        m_wr;
  logic [2:0]  m_size;
  logic [63:0] m_addr, m_data;
  logic [7:0]  m_strb;

  // Grant order seen on the bus: 1 = fetch, 2 = data
  int   obs[$];
  logic prev_cv = 1'b0;
  logic seen_iok, seen_dok;

  // Called at posedge+1 with inputs driven; samples at posedge+2.
  task automatic check_model();
    logic fin;
    #1;
    fin = (m_owner != 0) && cresp_ready && cresp_last && !reset;
    chk("creq_valid", creq_valid, m_owner != 0);
    if (m_owner != 0) begin
      chk("creq_is_write", creq_is_write, m_wr);
      chk("creq_size",     creq_size,     m_size);
      chk("creq_addr",     creq_addr,     m_addr);
      chk("creq_strobe",   creq_strobe,   m_strb);
      chk("creq_data",     creq_data,     m_data);
    end
    chk("iresp_ok", iresp_ok, fin && m_owner == 1);
    chk("dresp_ok", dresp_ok, fin && m_owner == 2);
    chk("Iwait", Iwait, ireq_valid && !(fin && m_owner == 1));
    chk("Dwait", Dwait, dreq_valid && !(fin && m_owner == 2));
    if (fin && m_owner == 1) chk("iresp_data", iresp_data, cresp_data);
    if (fin && m_owner == 2) chk("dresp_data", dresp_data, cresp_data);
    seen_iok = iresp_ok;
    seen_dok = dresp_ok;
    if (creq_valid && !prev_cv) obs.push_back(creq_is_write ? 2 : 1);
    prev_cv = creq_valid;
    // next-edge update
    if (reset) begin
      m_owner = 0; m_streak = 0;
    end else if (m_owner != 0) begin
      if (fin) m_owner = 0;
    end else if (ireq_valid || dreq_valid) begin
      if (ireq_valid && (!dreq_valid || m_streak == SMAX)) begin
        m_owner = 1; m_streak = 0;
        m_wr = 1'b0; m_size = 3'd3; m_addr = ireq_addr; m_strb = '0; m_data = '0;
      end else begin
        m_owner = 2;
        m_streak = ireq_valid ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
        m_wr = dreq_is_write; m_size = dreq_size; m_addr = dreq_addr;
        m_strb = dreq_is_write ? dreq_strobe : '0; m_data = dreq_data;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ireq_valid = 0; ireq_addr = '0; dreq_valid = 0; dreq_is_write = 0;
    dreq_size = 3'd3; dreq_addr = '0; dreq_strobe = '0; dreq_data = '0;
    cresp_ready = 0; cresp_last = 1; cresp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    check_model(); advance();
    reset = 0;
  endtask

  typedef struct {
    logic ir, dr, cr;
    logic e_cv, e_iok, e_dok, e_iw, e_dw;
  } vec_t;
  vec_t tbl[13];

  int guard;
  int stores;

  initial begin
    reset = 1; idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    // reset state, still in reset
    check_model();
    chk("reset_state", dut.state_q, IDLE);
    chk("reset_starve", dut.starve_cnt, 0);
    advance();
    reset = 0;

    // ---- table: single fetch, then D-before-I tie, then stray response in IDLE
    tbl[0]  = '{1,0,0, 0,0,0,1,0};
    tbl[1]  = '{1,0,0, 1,0,0,1,0};
    tbl[2]  = '{1,0,0, 1,0,0,1,0};
    tbl[3]  = '{1,0,0, 1,0,0,1,0};
    tbl[4]  = '{1,0,1, 1,1,0,0,0};
    tbl[5]  = '{0,0,0, 0,0,0,0,0};
    tbl[6]  = '{1,1,0, 0,0,0,1,1};
    tbl[7]  = '{1,1,0, 1,0,0,1,1};
    tbl[8]  = '{1,1,1, 1,0,1,1,0};
    tbl[9]  = '{1,0,0, 0,0,0,1,0};
    tbl[10] = '{1,0,1, 1,1,0,0,0};
    tbl[11] = '{0,0,1, 0,0,0,0,0};
    tbl[12] = '{0,0,0, 0,0,0,0,0};
    ireq_addr = 64'h8000_0000; dreq_addr = 64'h8000_1000; dreq_is_write = 0;
    for (int i = 0; i < 13; i++) begin
      ireq_valid = tbl[i].ir; dreq_valid = tbl[i].dr; cresp_ready = tbl[i].cr;
      cresp_data = {32'hC0DE_0000, 32'(i)};
      check_model();
      chk($sformatf("tbl%0d_cv", i),  creq_valid, tbl[i].e_cv);
      chk($sformatf("tbl%0d_iok", i), iresp_ok,   tbl[i].e_iok);
      chk($sformatf("tbl%0d_dok", i), dresp_ok,   tbl[i].e_dok);
      chk($sformatf("tbl%0d_iw", i),  Iwait,      tbl[i].e_iw);
      chk($sformatf("tbl%0d_dw", i),  Dwait,      tbl[i].e_dw);
      if (i == 1) begin
        chk("fetch_size", creq_size, MSIZE8);
        chk("fetch_addr", creq_addr, 64'h8000_0000);
      end
      if (i == 7) chk("load_addr", creq_addr, 64'h8000_1000);
      if (i == 12) chk("idle_resp_state", dut.state_q, IDLE);
      advance();
    end

    // ---- starvation: fetch held while five stores stream in
    do_reset();
    obs.delete(); prev_cv = 0;
    ireq_valid = 1; ireq_addr = 64'h8000_0040;
    dreq_valid = 1; dreq_is_write = 1; dreq_strobe = 8'hFF; stores = 0;
    dreq_addr = 64'h9000_0000; dreq_data = 64'hD000_0000;
    guard = 0;
    while (!(stores == 5 && !ireq_valid) && guard < 200) begin
      cresp_ready = creq_valid;
      if (creq_valid && !creq_is_write) chk("starve_cnt_after_i", dut.starve_cnt, 0);
      check_model(); advance();
      if (seen_dok) begin
        stores++;
        if (stores < 5) begin dreq_addr += 8; dreq_data += 1; end
        else dreq_valid = 0;
      end
      if (seen_iok) ireq_valid = 0;
      guard++;
    end
    chk("starve_timeout", guard < 200, 1);
    chk("starve_grants", obs.size(), 6);
    for (int i = 0; i < 6 && i < obs.size(); i++)
      chk($sformatf("starve_order%0d", i), obs[i], (i == 4) ? 1 : 2);
    cresp_ready = 0;

    // ---- store: strobe/data carried and held, then reset mid-transaction
    do_reset();
    dreq_valid = 1; dreq_is_write = 1; dreq_size = 3'd3; dreq_addr = 64'h8000_2000;
    dreq_strobe = 8'h0F; dreq_data = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 5; i++) begin
      cresp_ready = (i == 4);
      check_model();
      if (i > 0) begin
        chk("store_strobe", creq_strobe, 8'h0F);
        chk("store_data", creq_data, 64'h1122_3344_5566_7788);
      end
      if (i == 4) chk("store_dok", dresp_ok, 1);
      advance();
    end
    cresp_ready = 0;
    check_model(); advance();            // IDLE, store re-granted
    dreq_valid = 1; check_model(); advance();   // BUSY_D
    chk("pre_reset_cv", creq_valid, 1);
    reset = 1; check_model(); advance();
    reset = 0; dreq_valid = 0; cresp_ready = 1;
    check_model();
    chk("rst_mid_cv", creq_valid, 0);
    chk("rst_mid_dok", dresp_ok, 0);
    chk("rst_mid_state", dut.state_q, IDLE);
    advance();
    cresp_ready = 0;

    // ---- random traffic against the reference model
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      if (seen_iok) ireq_valid = 0;
      else if (!ireq_valid && $urandom_range(0, 2) == 0) begin
        ireq_valid = 1; ireq_addr = {32'h0, $urandom} & ~64'h3;
      end
      if (seen_dok) dreq_valid = 0;
      else if (!dreq_valid && $urandom_range(0, 2) == 0) begin
        dreq_valid = 1; dreq_is_write = $urandom_range(0, 1);
        dreq_size = 3'($urandom_range(0, 3)); dreq_addr = {$urandom, $urandom};
        dreq_strobe = 8'($urandom); dreq_data = {$urandom, $urandom};
      end
      cresp_ready = creq_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cresp_data = {$urandom, $urandom};
      check_model(); advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
